// File: rtl/ocx_tlx_vcx_fifo_ctl.sv
// ---------------------------------------------------------------------------
// ocx_tlx_vcx_fifo_ctl
//
// Multi-virtual-channel receive FIFO controller. Parsed command/response info
// is written into one shared RAM that is split into NUM_VC equal regions of
// 2^ADDR_WIDTH entries. Each VC keeps three pointers:
//   wr_ptr - tentative write pointer (advances on every accepted write)
//   vptr   - verified pointer (catches up to wr_ptr on a CRC-good commit)
//   rd_ptr - read pointer (advances on every issued read)
// A CRC error rolls every wr_ptr back to its vptr. Committed entries are read
// out under per-VC AFU credit control by a round-robin arbiter.
//
// Ports:
//   tlx_clk, reset            clock, synchronous active-high reset
//   afu_tlx_initial_credit    7 bits per VC, loaded in the first cycle out of reset
//   afu_tlx_credit_return     one-cycle credit return pulse per VC
//   fp_rcv_valid/vc/info      parsed entry to store
//   commit                    per-VC CRC-good pulse
//   crc_error                 rollback pulse for all VCs
//   wr_ena/wr_addr/wr_data    RAM write port, address {vc, ptr}
//   rd_ena/rd_addr/rd_vc      RAM read port, address {vc, ptr}
//   vc_empty/vc_full          per-VC status from registered pointers
//   overflow_err/credit_err   sticky error flags
//
// Handshake: fp_rcv_valid has no ready. An entry is accepted exactly when
// wr_ena is high in the same cycle; an entry presented to a full VC or during
// crc_error is dropped. rd_ena is a one-cycle request to the RAM and always
// consumes one credit of rd_vc; the AFU returns credits with
// afu_tlx_credit_return.
// ---------------------------------------------------------------------------
module ocx_tlx_vcx_fifo_ctl #(
    parameter int  NUM_VC       = 2,
    parameter int  ADDR_WIDTH   = 7,
    parameter int  DATA_WIDTH   = 56,
    parameter int  CREDIT_WIDTH = 8,
    localparam int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                         tlx_clk,
    input  logic                         reset,
    input  logic [7*NUM_VC-1:0]          afu_tlx_initial_credit,
    input  logic [NUM_VC-1:0]            afu_tlx_credit_return,
    input  logic                         fp_rcv_valid,
    input  logic [VC_W-1:0]              fp_rcv_vc,
    input  logic [DATA_WIDTH-1:0]        fp_rcv_info,
    input  logic [NUM_VC-1:0]            commit,
    input  logic                         crc_error,
    output logic                         wr_ena,
    output logic [VC_W+ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         rd_ena,
    output logic [VC_W+ADDR_WIDTH-1:0]   rd_addr,
    output logic [VC_W-1:0]              rd_vc,
    output logic [NUM_VC-1:0]            vc_empty,
    output logic [NUM_VC-1:0]            vc_full,
    output logic                         overflow_err,
    output logic                         credit_err
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]           FULL_OCC   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;

    // Registered state
    logic [NUM_VC-1:0][PW-1:0]           wr_ptr_q, vptr_q, rd_ptr_q;
    logic [NUM_VC-1:0][CREDIT_WIDTH-1:0] credit_q;
    logic [VC_W-1:0]                     prio_q;
    logic                                init_q;
    logic                                overflow_err_q, credit_err_q;

    // Next-state values
    logic [NUM_VC-1:0][PW-1:0]           wr_ptr_d, vptr_d, rd_ptr_d;
    logic [NUM_VC-1:0][CREDIT_WIDTH-1:0] credit_d;
    logic [VC_W-1:0]                     prio_d;
    logic                                credit_sat;

    // Combinational helpers
    logic [NUM_VC-1:0][PW-1:0] occ;
    logic [NUM_VC-1:0]         readable;
    logic [NUM_VC-1:0]         eligible;
    logic [NUM_VC-1:0]         rd_take;
    logic [VC_W-1:0]           wr_vc;
    logic                      vc_ok;
    logic                      full_sel;
    logic                      overflow_set;
    logic                      any_elig;
    logic [VC_W-1:0]           grant_vc;
    logic [VC_W-1:0]           arb_vc;
    int                        arb_idx;

    // VC select for the write port. With a single VC the VC field is tied to
    // zero; with a non-power-of-two VC count, out-of-range VC numbers are
    // ignored rather than aliased onto a real VC.
    if (NUM_VC == 1) begin : g_one_vc
        assign wr_vc = '0;
        assign vc_ok = 1'b1;
    end else if ((1 << VC_W) == NUM_VC) begin : g_pow2_vc
        assign wr_vc = fp_rcv_vc;
        assign vc_ok = 1'b1;
    end else begin : g_npow2_vc
        assign wr_vc = fp_rcv_vc;
        assign vc_ok = (int'(fp_rcv_vc) < NUM_VC);
    end

    // Per-VC status from registered pointers
    always_comb begin
        occ      = '0;
        readable = '0;
        eligible = '0;
        vc_full  = '0;
        vc_empty = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            occ[v]      = wr_ptr_q[v] - rd_ptr_q[v];
            vc_full[v]  = (occ[v] == FULL_OCC);
            readable[v] = (vptr_q[v] != rd_ptr_q[v]);
            vc_empty[v] = ~readable[v];
            eligible[v] = readable[v] && (credit_q[v] != '0);
        end
    end

    // Write path
    assign full_sel     = vc_full[wr_vc];
    assign wr_ena       = ~reset & fp_rcv_valid & vc_ok & ~full_sel & ~crc_error;
    assign overflow_set = ~reset & fp_rcv_valid & vc_ok & full_sel;
    assign wr_addr      = {wr_vc, wr_ptr_q[wr_vc][ADDR_WIDTH-1:0]};
    assign wr_data      = fp_rcv_info;

    // Round-robin arbiter: first eligible VC at or above prio, wrapping
    always_comb begin
        any_elig = 1'b0;
        grant_vc = '0;
        arb_idx  = 0;
        arb_vc   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            arb_idx = int'(prio_q) + i;
            if (arb_idx >= NUM_VC) begin
                arb_idx = arb_idx - NUM_VC;
            end
            arb_vc = VC_W'(arb_idx);
            if (!any_elig && eligible[arb_vc]) begin
                any_elig = 1'b1;
                grant_vc = arb_vc;
            end
        end
    end

    // Reads are held off during the credit-load cycle after reset
    assign rd_ena  = ~reset & ~init_q & any_elig;
    assign rd_vc   = grant_vc;
    assign rd_addr = {grant_vc, rd_ptr_q[grant_vc][ADDR_WIDTH-1:0]};

    // Next-state logic
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        vptr_d     = vptr_q;
        rd_ptr_d   = rd_ptr_q;
        credit_d   = credit_q;
        prio_d     = prio_q;
        credit_sat = 1'b0;
        rd_take    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_ena && (wr_vc == VC_W'(v))) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PW'(1);
            end
            // Rollback wins over both the write and any commit this cycle.
            // A commit captures the post-write pointer so a same-cycle write
            // becomes readable with it.
            if (crc_error) begin
                wr_ptr_d[v] = vptr_q[v];
            end else if (commit[v]) begin
                vptr_d[v] = wr_ptr_d[v];
            end

            rd_take[v] = rd_ena && (grant_vc == VC_W'(v));
            if (rd_take[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);
            end

            // Credit counter: initial load beats any return in the init cycle;
            // a grant and a return together cancel out.
            if (init_q) begin
                credit_d[v] = CREDIT_WIDTH'(afu_tlx_initial_credit[7*v +: 7]);
            end else if (rd_take[v] && !afu_tlx_credit_return[v]) begin
                credit_d[v] = credit_q[v] - CREDIT_WIDTH'(1);
            end else if (!rd_take[v] && afu_tlx_credit_return[v]) begin
                if (credit_q[v] == CREDIT_MAX) begin
                    credit_sat = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CREDIT_WIDTH'(1);
                end
            end
        end
        if (rd_ena) begin
            prio_d = (grant_vc == VC_W'(NUM_VC - 1)) ? '0 : grant_vc + VC_W'(1);
        end
    end

    always_ff @(posedge tlx_clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            vptr_q         <= '0;
            rd_ptr_q       <= '0;
            credit_q       <= '0;
            prio_q         <= '0;
            init_q         <= 1'b1;
            overflow_err_q <= 1'b0;
            credit_err_q   <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            vptr_q         <= vptr_d;
            rd_ptr_q       <= rd_ptr_d;
            credit_q       <= credit_d;
            prio_q         <= prio_d;
            init_q         <= 1'b0;
            overflow_err_q <= overflow_err_q | overflow_set;
            credit_err_q   <= credit_err_q | credit_sat;
        end
    end

    assign overflow_err = overflow_err_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_ocx_tlx_vcx_fifo_ctl.sv
// ---------------------------------------------------------------------------
// Directed bench for ocx_tlx_vcx_fifo_ctl. Two instances share every input:
// dut uses the default geometry (ADDR_WIDTH=7), dut_s uses ADDR_WIDTH=2 for
// the full/wrap scenario. Reads of dut are checked against an expected queue
// of RAM read addresses by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_ocx_tlx_vcx_fifo_ctl;

    logic        tlx_clk;
    logic        reset;
    logic [13:0] afu_tlx_initial_credit;
    logic [1:0]  afu_tlx_credit_return;
    logic        fp_rcv_valid;
    logic [0:0]  fp_rcv_vc;
    logic [55:0] fp_rcv_info;
    logic [1:0]  commit;
    logic        crc_error;

    logic        wr_ena, rd_ena, overflow_err, credit_err;
    logic [7:0]  wr_addr, rd_addr;
    logic [55:0] wr_data;
    logic [0:0]  rd_vc;
    logic [1:0]  vc_empty, vc_full;

    logic        wr_ena_s, rd_ena_s, overflow_err_s, credit_err_s;
    logic [2:0]  wr_addr_s, rd_addr_s;
    logic [55:0] wr_data_s;
    logic [0:0]  rd_vc_s;
    logic [1:0]  vc_empty_s, vc_full_s;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_e;

    ocx_tlx_vcx_fifo_ctl dut (
        .tlx_clk(tlx_clk), .reset(reset),
        .afu_tlx_initial_credit(afu_tlx_initial_credit),
        .afu_tlx_credit_return(afu_tlx_credit_return),
        .fp_rcv_valid(fp_rcv_valid), .fp_rcv_vc(fp_rcv_vc), .fp_rcv_info(fp_rcv_info),
        .commit(commit), .crc_error(crc_error),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_ena(rd_ena), .rd_addr(rd_addr), .rd_vc(rd_vc),
        .vc_empty(vc_empty), .vc_full(vc_full),
        .overflow_err(overflow_err), .credit_err(credit_err)
    );

    ocx_tlx_vcx_fifo_ctl #(.ADDR_WIDTH(2)) dut_s (
        .tlx_clk(tlx_clk), .reset(reset),
        .afu_tlx_initial_credit(afu_tlx_initial_credit),
        .afu_tlx_credit_return(afu_tlx_credit_return),
        .fp_rcv_valid(fp_rcv_valid), .fp_rcv_vc(fp_rcv_vc), .fp_rcv_info(fp_rcv_info),
        .commit(commit), .crc_error(crc_error),
        .wr_ena(wr_ena_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .rd_ena(rd_ena_s), .rd_addr(rd_addr_s), .rd_vc(rd_vc_s),
        .vc_empty(vc_empty_s), .vc_full(vc_full_s),
        .overflow_err(overflow_err_s), .credit_err(credit_err_s)
    );

    // Clock
    initial tlx_clk = 1'b0;
    always #5 tlx_clk = ~tlx_clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tlx_clk);
        #1;
    endtask

    // Read monitor / scoreboard for the default-geometry instance
    always @(negedge tlx_clk) begin
        if (!reset && rd_ena) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", {56'd0, rd_addr}, 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_addr", rd_addr, mon_e);
                check("rd_vc", rd_vc, mon_e[7]);
            end
        end
    end

    task automatic do_reset(input logic [13:0] init_cr, input logic ret_in_init);
        afu_tlx_initial_credit = init_cr;
        afu_tlx_credit_return  = '0;
        fp_rcv_valid = 1'b0;
        fp_rcv_vc    = '0;
        fp_rcv_info  = '0;
        commit       = '0;
        crc_error    = 1'b0;
        reset        = 1'b1;
        exp_q.delete();
        tick();
        tick();
        check("rst_rd_ena", rd_ena, 1'b0);
        check("rst_vc_empty", vc_empty, 2'b11);
        check("rst_vc_full", vc_full, 2'b00);
        check("rst_overflow", overflow_err, 1'b0);
        check("rst_credit_err", credit_err, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h00);
        reset = 1'b0;
        afu_tlx_credit_return = ret_in_init ? 2'b11 : 2'b00;
        tick();
        afu_tlx_credit_return = '0;
    endtask

    task automatic do_write(input int vc, input logic [55:0] d, input logic [7:0] exp_addr);
        fp_rcv_valid = 1'b1;
        fp_rcv_vc    = 1'(vc);
        fp_rcv_info  = d;
        #1;
        check("wr_ena", wr_ena, 1'b1);
        check("wr_addr", wr_addr, exp_addr);
        check("wr_data", wr_data, d);
        tick();
        fp_rcv_valid = 1'b0;
    endtask

    task automatic pulse_commit(input logic [1:0] m);
        commit = m;
        tick();
        commit = '0;
    endtask

    task automatic wait_drain(input int n, input string tag);
        repeat (n) tick();
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        // ---------------- Init and commit ----------------
        do_reset(14'h0002, 1'b0);
        check("s1_credit0_init", dut.credit_q[0], 8'd2);
        for (int i = 0; i < 3; i++) do_write(0, 56'hA0 + 56'(i), 8'(i));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        pulse_commit(2'b01);
        wait_drain(6, "s1_two_reads");
        check("s1_stall", rd_ena, 1'b0);
        check("s1_credit0_zero", dut.credit_q[0], 8'd0);
        check("s1_vc_empty", vc_empty, 2'b10);
        exp_q.push_back(8'h02);
        afu_tlx_credit_return = 2'b01;
        tick();
        afu_tlx_credit_return = '0;
        wait_drain(4, "s1_third_read");
        check("s1_vc_empty_end", vc_empty, 2'b11);

        // ---------------- Rollback ----------------
        do_reset(14'h0400, 1'b0);
        for (int i = 0; i < 4; i++) do_write(1, 56'hB0 + 56'(i), 8'h80 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 + 8'(i));
        pulse_commit(2'b10);
        do_write(1, 56'hB4, 8'h84);
        do_write(1, 56'hB5, 8'h85);
        crc_error = 1'b1;
        tick();
        crc_error = 1'b0;
        wait_drain(6, "s2_four_reads");
        check("s2_vc_empty", vc_empty, 2'b11);
        do_write(1, 56'hB6, 8'h84);
        wait_drain(4, "s2_no_read_uncommitted");

        // ---------------- Round-robin ----------------
        do_reset(14'h0282, 1'b0);
        for (int i = 0; i < 3; i++) do_write(0, 56'hC0 + 56'(i), 8'(i));
        for (int i = 0; i < 3; i++) do_write(1, 56'hD0 + 56'(i), 8'h80 + 8'(i));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h82);
        pulse_commit(2'b11);
        wait_drain(8, "s3_rr_reads");
        check("s3_credit0_zero", dut.credit_q[0], 8'd0);
        check("s3_credit1", dut.credit_q[1], 8'd2);
        check("s3_vc_empty", vc_empty, 2'b10);
        check("s3_stall", rd_ena, 1'b0);

        // ---------------- Full and wrap (ADDR_WIDTH=2 instance) ----------------
        do_reset(14'h0008, 1'b0);
        for (int i = 0; i < 5; i++) begin
            fp_rcv_valid = 1'b1;
            fp_rcv_vc    = 1'b0;
            fp_rcv_info  = 56'hE0 + 56'(i);
            exp_q.push_back(8'(i));
            #1;
            check("s4_full_before", vc_full_s[0], (i == 4));
            check("s4_wr_ena", wr_ena_s, (i < 4));
            if (i < 4) check("s4_wr_addr", wr_addr_s, 3'(i));
            tick();
        end
        fp_rcv_valid = 1'b0;
        check("s4_overflow_small", overflow_err_s, 1'b1);
        check("s4_overflow_main", overflow_err, 1'b0);
        pulse_commit(2'b01);
        wait_drain(8, "s4_main_reads");
        check("s4_small_empty", vc_empty_s[0], 1'b1);
        check("s4_small_not_full", vc_full_s[0], 1'b0);
        fp_rcv_valid = 1'b1;
        fp_rcv_info  = 56'hEF;
        exp_q.push_back(8'h05);
        #1;
        check("s4_wrap_wr_ena", wr_ena_s, 1'b1);
        check("s4_wrap_wr_addr", wr_addr_s, 3'h0);
        tick();
        fp_rcv_valid = 1'b0;
        check("s4_wrap_bit", dut_s.wr_ptr_q[0], 3'b101);
        pulse_commit(2'b01);
        #1;
        check("s4_not_empty", vc_empty_s[0], 1'b0);
        check("s4_small_rd_ena", rd_ena_s, 1'b1);
        check("s4_small_rd_addr", rd_addr_s, 3'h0);
        wait_drain(4, "s4_main_last_read");
        check("s4_overflow_sticky", overflow_err_s, 1'b1);

        // ---------------- Simultaneous events ----------------
        do_reset(14'h0204, 1'b0);
        // write + commit in one cycle
        fp_rcv_valid = 1'b1;
        fp_rcv_vc    = 1'b0;
        fp_rcv_info  = 56'hF0;
        commit       = 2'b01;
        exp_q.push_back(8'h00);
        tick();
        fp_rcv_valid = 1'b0;
        commit       = '0;
        #1;
        check("s5_wc_rd_ena", rd_ena, 1'b1);
        check("s5_wc_rd_addr", rd_addr, 8'h00);
        tick();
        // write + crc_error (+ commit) in one cycle
        fp_rcv_valid = 1'b1;
        fp_rcv_vc    = 1'b1;
        fp_rcv_info  = 56'hF1;
        commit       = 2'b10;
        crc_error    = 1'b1;
        #1;
        check("s5_crc_wr_ena", wr_ena, 1'b0);
        tick();
        fp_rcv_valid = 1'b0;
        commit       = '0;
        crc_error    = 1'b0;
        check("s5_crc_vc_empty", vc_empty, 2'b11);
        do_write(1, 56'hF2, 8'h80);
        check("s5_credit0", dut.credit_q[0], 8'd3);
        // grant + credit return in one cycle
        fp_rcv_valid = 1'b1;
        fp_rcv_vc    = 1'b0;
        fp_rcv_info  = 56'hF3;
        commit       = 2'b01;
        exp_q.push_back(8'h01);
        tick();
        fp_rcv_valid = 1'b0;
        commit       = '0;
        afu_tlx_credit_return = 2'b01;
        #1;
        check("s5_gr_rd_ena", rd_ena, 1'b1);
        tick();
        afu_tlx_credit_return = '0;
        check("s5_credit_hold", dut.credit_q[0], 8'd3);
        wait_drain(4, "s5_reads");

        // ---------------- Credit saturation ----------------
        do_reset(14'h007F, 1'b1);
        check("s6_init_wins0", dut.credit_q[0], 8'd127);
        check("s6_init_wins1", dut.credit_q[1], 8'd0);
        afu_tlx_credit_return = 2'b01;
        repeat (128) tick();
        check("s6_credit_max", dut.credit_q[0], 8'd255);
        check("s6_no_err_yet", credit_err, 1'b0);
        tick();
        afu_tlx_credit_return = '0;
        check("s6_credit_sat", dut.credit_q[0], 8'd255);
        check("s6_credit_err", credit_err, 1'b1);
        check("s6_no_reads", rd_ena, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
